// File: rtl/tmr_regfile_scrub.sv
// Triple-redundant 32x32 register file with majority-voted read ports,
// a background scrubber that rewrites voted values on idle write cycles, and a fault-injection port.
module tmr_regfile_scrub #(
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we3,
   input  logic [4:0]          ra1,
   input  logic [4:0]          ra2,
   input  logic [4:0]          wa3,
   input  logic [31:0]         wd3,
   output logic [31:0]         rd1,
   output logic [31:0]         rd2,
   output logic                rd_mismatch,
   input  logic                inj_en,
   input  logic [1:0]          inj_copy,
   input  logic [4:0]          inj_addr,
   input  logic [31:0]         inj_mask,
   output logic [4:0]          scrub_ptr,
   output logic                scrub_corrected,
   output logic [ERRCNT_W-1:0] err_count
);

   logic [31:0]         cp_q [3][32];
   logic [31:0]         cp_d [3][32];
   logic [4:0]          scrub_ptr_q, scrub_ptr_d;
   logic                corr_q, corr_d;
   logic [ERRCNT_W-1:0] cnt_q, cnt_d;
   logic                wr_act_s;
   logic                scrub_mis_s;
   logic [31:0]         ptr_vote_s;

   function automatic logic [31:0] vote3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic disagree3(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
      return (a != b) || (b != c);
   endfunction

   // Next-state for the three copies, scrub pointer and correction accounting
   always_comb begin
      wr_act_s    = we3 && (wa3 != 5'd0);
      ptr_vote_s  = vote3(cp_q[0][scrub_ptr_q], cp_q[1][scrub_ptr_q], cp_q[2][scrub_ptr_q]);
      scrub_mis_s = !wr_act_s && disagree3(cp_q[0][scrub_ptr_q], cp_q[1][scrub_ptr_q],
                                           cp_q[2][scrub_ptr_q]);
      for (int k = 0; k < 3; k++) begin
         cp_d[k][0] = 32'd0;
         for (int i = 1; i < 32; i++) begin
            if (wr_act_s && (wa3 == 5'(i))) begin
               cp_d[k][i] = wd3;
            end else if (!wr_act_s && (scrub_ptr_q == 5'(i))) begin
               cp_d[k][i] = ptr_vote_s;
            end else begin
               cp_d[k][i] = cp_q[k][i];
            end
            // Injection flips on top of whatever this cycle stores
            if (inj_en && (inj_copy == 2'(k)) && (inj_addr == 5'(i))) begin
               cp_d[k][i] = cp_d[k][i] ^ inj_mask;
            end else begin
               cp_d[k][i] = cp_d[k][i];
            end
         end
      end
      if (wr_act_s) begin
         scrub_ptr_d = scrub_ptr_q;
      end else if (scrub_ptr_q == 5'd31) begin
         scrub_ptr_d = 5'd1;
      end else begin
         scrub_ptr_d = scrub_ptr_q + 5'd1;
      end
      corr_d = scrub_mis_s;
      if (scrub_mis_s && (cnt_q != {ERRCNT_W{1'b1}})) begin
         cnt_d = cnt_q + ERRCNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) begin
               cp_q[k][i] <= 32'd0;
            end
         end
         scrub_ptr_q <= 5'd1;
         corr_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cp_q        <= cp_d;
         scrub_ptr_q <= scrub_ptr_d;
         corr_q      <= corr_d;
         cnt_q       <= cnt_d;
      end
   end

   // Voted read ports and read-side disagreement flag
   always_comb begin
      if (ra1 == 5'd0) begin
         rd1 = 32'd0;
      end else begin
         rd1 = vote3(cp_q[0][ra1], cp_q[1][ra1], cp_q[2][ra1]);
      end
      if (ra2 == 5'd0) begin
         rd2 = 32'd0;
      end else begin
         rd2 = vote3(cp_q[0][ra2], cp_q[1][ra2], cp_q[2][ra2]);
      end
      rd_mismatch = ((ra1 != 5'd0) && disagree3(cp_q[0][ra1], cp_q[1][ra1], cp_q[2][ra1])) ||
                    ((ra2 != 5'd0) && disagree3(cp_q[0][ra2], cp_q[1][ra2], cp_q[2][ra2]));
   end

   assign scrub_ptr       = scrub_ptr_q;
   assign scrub_corrected = corr_q;
   assign err_count       = cnt_q;

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// Directed bench for tmr_regfile_scrub: expected values are queued as stimulus is
// driven and popped when the matching DUT output is sampled.
module tb_tmr_regfile_scrub;

   localparam int EW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          we3;
   logic [4:0]    ra1, ra2, wa3;
   logic [31:0]   wd3;
   logic [31:0]   rd1, rd2;
   logic          rd_mismatch;
   logic          inj_en;
   logic [1:0]    inj_copy;
   logic [4:0]    inj_addr;
   logic [31:0]   inj_mask;
   logic [4:0]    scrub_ptr;
   logic          scrub_corrected;
   logic [EW-1:0] err_count;

   logic [31:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [4:0]    mptr;

   tmr_regfile_scrub #(.ERRCNT_W(EW)) dut (
      .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3),
      .rd1(rd1), .rd2(rd2), .rd_mismatch(rd_mismatch), .inj_en(inj_en),
      .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
      .scrub_ptr(scrub_ptr), .scrub_corrected(scrub_corrected), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h, nothing expected", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   // Advance the pointer model with the inputs about to be sampled, then step one cycle
   task automatic tick();
      if (reset) mptr = 5'd1;
      else if (!(we3 && (wa3 != 5'd0))) mptr = (mptr == 5'd31) ? 5'd1 : mptr + 5'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ptr(input logic [4:0] target);
      for (int n = 0; n < 40 && mptr != target; n++) tick();
      exp(32'(target));
      chk("wait_ptr", 32'(scrub_ptr));
   endtask

   task automatic inject(input logic [1:0] copy, input logic [4:0] addr, input logic [31:0] mask);
      inj_en = 1'b1; inj_copy = copy; inj_addr = addr; inj_mask = mask;
      tick();
      inj_en = 1'b0; inj_copy = 2'd0; inj_addr = 5'd0; inj_mask = 32'd0;
   endtask

   initial begin
      reset = 1'b1; we3 = 1'b0; ra1 = 5'd0; ra2 = 5'd0; wa3 = 5'd0; wd3 = 32'd0;
      inj_en = 1'b0; inj_copy = 2'd0; inj_addr = 5'd0; inj_mask = 32'd0; mptr = 5'd1;
      tick(); tick();
      exp(32'd1); chk("rst_ptr", 32'(scrub_ptr));
      exp(32'd0); chk("rst_corr", 32'(scrub_corrected));
      exp(32'd0); chk("rst_cnt", 32'(err_count));
      exp(32'd0); chk("rst_rd1", rd1);
      exp(32'd0); chk("rst_mis", 32'(rd_mismatch));
      reset = 1'b0;

      // Write r5 and read it back; write with wa3=0 is a no-op
      we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd0;
      tick();
      exp(32'hDEADBEEF); chk("rd1_r5", rd1);
      exp(32'd0);        chk("mis_r5", 32'(rd_mismatch));
      exp(32'd1);        chk("ptr_hold_on_write", 32'(scrub_ptr));
      wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
      tick();
      exp(32'd0);        chk("rd2_r0", rd2);
      exp(32'd2);        chk("ptr_wa0_is_scrub", 32'(scrub_ptr));

      // Single-copy upset at r7 corrected by the scrubber
      wa3 = 5'd7; wd3 = 32'h12345678;
      tick();
      we3 = 1'b0; wa3 = 5'd0; wd3 = 32'd0; ra1 = 5'd7;
      inject(2'd1, 5'd7, 32'h000000FF);
      exp(32'h12345678); chk("rd1_r7_voted", rd1);
      exp(32'd1);        chk("mis_r7", 32'(rd_mismatch));
      wait_ptr(5'd7);
      tick();
      exp(32'd1);        chk("corr_r7", 32'(scrub_corrected));
      exp(32'd1);        chk("cnt_r7", 32'(err_count));
      exp(32'd0);        chk("mis_r7_fixed", 32'(rd_mismatch));
      exp(32'h12345678); chk("rd1_r7_fixed", rd1);
      tick();
      exp(32'd0);        chk("corr_pulse_end", 32'(scrub_corrected));

      // Idle pass: pointer sequence 1..31 then back to 1
      wait_ptr(5'd1);
      for (int t = 1; t <= 31; t++) begin
         tick();
         exp(32'((t % 31) + 1));
         chk("ptr_seq", 32'(scrub_ptr));
      end
      exp(32'd1); chk("cnt_idle", 32'(err_count));

      // Scrubber stalls under a 10-cycle write burst
      wait_ptr(5'd4);
      we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h00000333;
      for (int t = 0; t < 10; t++) begin
         exp(32'd4); chk("ptr_stall", 32'(scrub_ptr));
         tick();
      end
      we3 = 1'b0; wa3 = 5'd0;
      exp(32'd4); chk("ptr_stall_end", 32'(scrub_ptr));
      tick();
      exp(32'd5); chk("ptr_resume", 32'(scrub_ptr));

      // Double fault at r9: vote flips and scrub commits the wrong value
      we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hA5A5A5A4; ra1 = 5'd9;
      tick();
      we3 = 1'b0; wa3 = 5'd0;
      inject(2'd0, 5'd9, 32'h1);
      inject(2'd2, 5'd9, 32'h1);
      exp(32'hA5A5A5A5); chk("rd1_r9_flipped", rd1);
      exp(32'd1);        chk("mis_r9", 32'(rd_mismatch));
      wait_ptr(5'd9);
      tick();
      exp(32'd1);        chk("corr_r9", 32'(scrub_corrected));
      exp(32'd2);        chk("cnt_r9", 32'(err_count));
      exp(32'd0);        chk("mis_r9_fixed", 32'(rd_mismatch));
      exp(32'hA5A5A5A5); chk("rd1_r9_fixed", rd1);
      tick();

      // Copy index 3 has no effect
      ra1 = 5'd5;
      inject(2'd3, 5'd5, 32'hFFFFFFFF);
      exp(32'd0);        chk("inj3_nomis", 32'(rd_mismatch));
      exp(32'hDEADBEEF); chk("inj3_rd1", rd1);

      // Drive the 2-bit counter into saturation
      inject(2'd1, 5'd16, 32'h1);
      wait_ptr(5'd16);
      tick();
      exp(32'd1); chk("corr_r16", 32'(scrub_corrected));
      exp(32'd3); chk("cnt_3", 32'(err_count));
      inject(2'd1, 5'd20, 32'h80000000);
      wait_ptr(5'd20);
      tick();
      exp(32'd1); chk("corr_r20", 32'(scrub_corrected));
      exp(32'd3); chk("cnt_sat", 32'(err_count));

      // Asynchronous reset mid-pass clears everything immediately
      ra1 = 5'd5; ra2 = 5'd7;
      #2;
      reset = 1'b1;
      mptr  = 5'd1;
      #1;
      exp(32'd1); chk("arst_ptr", 32'(scrub_ptr));
      exp(32'd0); chk("arst_corr", 32'(scrub_corrected));
      exp(32'd0); chk("arst_cnt", 32'(err_count));
      exp(32'd0); chk("arst_rd1", rd1);
      exp(32'd0); chk("arst_rd2", rd2);
      exp(32'd0); chk("arst_mis", 32'(rd_mismatch));
      tick();
      reset = 1'b0;
      tick();
      exp(32'd2); chk("post_rst_ptr", 32'(scrub_ptr));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmr_regfile_scrub.md
# tmr_regfile_scrub

Triple-modular-redundant replacement for the processor's three-ported register file, sitting directly upstream of the voted ALU and feeding its `a`/`b` operands. Three copies of the 32x32 array are written together. Both read ports return the bitwise majority of the copies. A background scrubber walks the array during idle write cycles and rewrites each entry with its voted value, so single-copy upsets are corrected before they accumulate. A fault-injection port lets the bench corrupt individual copies.

## Interface
- `ERRCNT_W`, default 8: width of the saturating scrub-correction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `we3`  in  1  architectural write enable.
- `ra1`, `ra2`  in  5 each  read addresses.
- `wa3`  in  5  write address.
- `wd3`  in  32  write data.
- `rd1`, `rd2`  out  32 each  voted read data; 0 when the address is 0.
- `rd_mismatch`  out  1  combinational; high when the copies disagree at a non-zero `ra1` or `ra2`.
- `inj_en`  in  1  fault-injection strobe.
- `inj_copy`  in  2  copy to corrupt: 0, 1 or 2. Value 3 means no effect.
- `inj_addr`  in  5  entry to corrupt.
- `inj_mask`  in  32  bits to flip (XOR).
- `scrub_ptr`  out  5  entry the scrubber visits this cycle.
- `scrub_corrected`  out  1  registered one-cycle pulse: the previous scrub found and fixed a mismatch.
- `err_count`  out  `ERRCNT_W`  saturating count of scrub corrections.

## Operation
- Storage: copies `c0`, `c1`, `c2`, each 32 x 32 bits.
- Entry 0 of every copy is never written, by architectural writes, scrub or injection, and always reads 0.
- Vote: `v[i] = (c0[i]&c1[i]) | (c0[i]&c2[i]) | (c1[i]&c2[i])`.
  - `rd1 = v[ra1]` and `rd2 = v[ra2]`, both combinational.
- Architectural write: when `we3` is high and `wa3` is non-zero, `wd3` goes into all three copies at `wa3`.
- Scrub cycle: any cycle in which no architectural write occurs (`we3` low, or `wa3` = 0).
  - All three copies at `scrub_ptr` are written with `v[scrub_ptr]`.
  - `scrub_ptr` advances: 1 to 2 … 31, then wraps 31 to 1. The value 0 is skipped.
- Write cycle: the scrubber stalls and `scrub_ptr` holds.
- Mismatch accounting: a mismatch exists when any copy at `scrub_ptr` differs from the vote during a scrub cycle. In that case:
  - `scrub_corrected` goes to 1 on the next edge, otherwise 0.
  - `err_count` increments, saturating at all-ones.
- Injection: when `inj_en` is high, `inj_copy` < 3 and `inj_addr` is non-zero, the selected copy's entry becomes its next value XOR `inj_mask`.
  - The next value is whatever the write or scrub this cycle stores; otherwise it is the held value.
  - Injection into the same entry as a scrub therefore survives until the next scrub pass.
- Double fault: two copies flipped in the same bit produce a wrong vote. The scrubber makes all copies consistent with that wrong value and counts it. This is a known limitation and is not flagged separately.

## Timing
- Reset (asynchronous) clears:
  - every entry of all three copies to 0;
  - `scrub_ptr` to 1;
  - `scrub_corrected` to 0;
  - `err_count` to 0.
- Consequences of reset:
  - `rd1`, `rd2` read 0 and `rd_mismatch` is 0.
  - Reset asserted mid-scrub or mid-write discards that cycle's update.
- Read latency: 0 cycles. Written data is visible on `rd1`/`rd2` the cycle after the write edge; there is no write-to-read bypass.
- Scrub latency: with no architectural writes, every entry is scrubbed once per 31 cycles. Each write cycle extends the pass by one cycle.
- Simultaneous events: `we3` to the same address as `scrub_ptr` means the write wins, no scrub occurs and the pointer holds.
- `rd_mismatch` reflects the current array contents only; it is unaffected by the same-cycle write or injection.

## Test plan
- Reset, then write `0xDEADBEEF` to r5 -> next cycle `rd1`(ra1=5) = `0xDEADBEEF`, `rd_mismatch`=0, and `rd2`(ra2=0) = 0 even after `we3` with `wa3`=0 and `wd3`=`0xFFFFFFFF`.
- Write `0x12345678` to r7, then inject copy 1, r7, mask `0x000000FF` -> `rd1` still `0x12345678` and `rd_mismatch`=1. When `scrub_ptr` reaches 7 with no writes: `scrub_corrected` pulses one cycle, `err_count` = 1, `rd_mismatch` returns to 0.
- Idle after reset with no writes -> `scrub_ptr` runs 1,2…31,1; period 31 cycles; `err_count` stays 0.
- Hold `we3`=1 (`wa3`=3) for 10 cycles while `scrub_ptr`=4 -> pointer stays 4 for all 10 cycles, then advances to 5 on the first idle cycle.
- Inject copy 0 and copy 2 at r9, mask `0x1` -> vote bit 0 flips. After the scrub at 9, `rd_mismatch`=0, the value is flipped in all copies, and `err_count` +1.
- Preload `err_count` near saturation via repeated inject/scrub (`ERRCNT_W`=2) -> counts 1,2,3,3. Assert reset mid-pass -> all outputs return to reset values immediately.
